screen_compositor: RTL and testbench

Parametrised successor to the fixed three-screen selector. Muxes NUM_SCREENS screen renderers onto one VGA colour output and one shared font ROM address bus. Adds frame-synchronous fade-out/fade-in transitions between screens, plus a registered 1-cycle pixel pipeline. Sits between the screen renderers (start/game/wait/...) and the VGA colour outputs.

---
 rtl/screen_compositor.sv | 174 +++++++++++++++++
 tb/tb_screen_compositor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_compositor.sv
// screen_compositor
// Muxes NUM_SCREENS screen renderers onto one VGA colour output and one shared
// font ROM address bus. It fades between screens in step with the frame, and
// each colour channel passes through a 1-cycle register.
//
// Optional feature macro: SCREEN_FADE_EN
//   defined   : a frame-synchronous fade-out / swap / fade-in FSM.
//   undefined : the output switches on the first frame_start that sees a new
//               screen_sel. Brightness stays full and busy stays 0.
//
// Ports
//   clk, reset        pixel clock, asynchronous active-high reset
//   frame_start       one-cycle pulse at the start of vertical blank
//   screen_sel        requested screen index (level signal)
//   src_red/green/blue packed per-screen colour, screen i at [i*COLOR_W +: COLOR_W]
//   src_font_addr     packed per-screen font address
//   font_address      font address of the active screen (combinational)
//   Red/Green/Blue    colour of the active screen scaled by the fade level (registered)
//   active_screen     screen currently driving the output
//   busy              high while a transition is in progress
module screen_compositor #(
    parameter int unsigned NUM_SCREENS = 4,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned FONT_ADDR_W = 11,
    parameter int unsigned FADE_STEPS  = 16,
    parameter logic [3*COLOR_W-1:0] DEFAULT_RGB = (3*COLOR_W)'(12'h362)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             frame_start,
    input  logic [$clog2(NUM_SCREENS)-1:0]   screen_sel,
    input  logic [NUM_SCREENS*COLOR_W-1:0]   src_red,
    input  logic [NUM_SCREENS*COLOR_W-1:0]   src_green,
    input  logic [NUM_SCREENS*COLOR_W-1:0]   src_blue,
    input  logic [NUM_SCREENS*FONT_ADDR_W-1:0] src_font_addr,
    output logic [FONT_ADDR_W-1:0]           font_address,
    output logic [COLOR_W-1:0]               Red,
    output logic [COLOR_W-1:0]               Green,
    output logic [COLOR_W-1:0]               Blue,
    output logic [$clog2(NUM_SCREENS)-1:0]   active_screen,
    output logic                             busy
);

    localparam int unsigned SEL_W  = $clog2(NUM_SCREENS);
    localparam int unsigned LVL_SH = $clog2(FADE_STEPS);
    localparam int unsigned LVL_W  = LVL_SH + 1;
    localparam int unsigned PROD_W = COLOR_W + LVL_SH + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_STEPS);

    logic [COLOR_W-1:0] sel_r;
    logic [COLOR_W-1:0] sel_g;
    logic [COLOR_W-1:0] sel_b;
    logic [LVL_W-1:0]   level;

    // Brightness scaling: (c * level) >> log2(FADE_STEPS)
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W-1:0]   l);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(l);
        return COLOR_W'(p >> LVL_SH);
    endfunction

    // Source select. An index with no screen behind it falls back to DEFAULT_RGB
    // and font address 0.
    always_comb begin
        sel_r        = DEFAULT_RGB[3*COLOR_W-1 -: COLOR_W];
        sel_g        = DEFAULT_RGB[2*COLOR_W-1 -: COLOR_W];
        sel_b        = DEFAULT_RGB[COLOR_W-1:0];
        font_address = '0;
        for (int unsigned i = 0; i < NUM_SCREENS; i++) begin
            if (active_screen == SEL_W'(i)) begin
                sel_r        = src_red[i*COLOR_W +: COLOR_W];
                sel_g        = src_green[i*COLOR_W +: COLOR_W];
                sel_b        = src_blue[i*COLOR_W +: COLOR_W];
                font_address = src_font_addr[i*FONT_ADDR_W +: FONT_ADDR_W];
            end
        end
    end

`ifdef SCREEN_FADE_EN
    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [SEL_W-1:0] active_nxt;

    // State, level and active-screen registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SHOW;
            level         <= LVL_FULL;
            active_screen <= '0;
        end else begin
            state         <= state_nxt;
            level         <= level_nxt;
            active_screen <= active_nxt;
        end
    end

    // Fade sequencing, advanced only on frame_start. Returning to the current
    // screen mid-fade reverses direction and keeps the level.
    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        active_nxt = active_screen;
        if (frame_start) begin
            case (state)
                SHOW: begin
                    if (screen_sel != active_screen) state_nxt = FADE_OUT;
                end
                FADE_OUT: begin
                    if (screen_sel == active_screen) begin
                        state_nxt = FADE_IN;
                    end else if (level == '0) begin
                        active_nxt = screen_sel;
                        state_nxt  = FADE_IN;
                    end else begin
                        level_nxt = level - LVL_W'(1);
                    end
                end
                FADE_IN: begin
                    if (screen_sel != active_screen) begin
                        state_nxt = FADE_OUT;
                    end else if (level == LVL_FULL) begin
                        state_nxt = SHOW;
                    end else begin
                        level_nxt = level + LVL_W'(1);
                    end
                end
                default: state_nxt = SHOW;
            endcase
        end
    end

    assign busy = (state != SHOW);
`else
    logic [SEL_W-1:0] active_nxt;

    assign level = LVL_FULL;

    // Active-screen register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) active_screen <= '0;
        else       active_screen <= active_nxt;
    end

    // Immediate swap on the first frame_start that sees a new selection
    always_comb begin
        active_nxt = active_screen;
        if (frame_start && (screen_sel != active_screen)) active_nxt = screen_sel;
    end

    assign busy = 1'b0;
`endif

    // Registered colour output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else begin
            Red   <= scale(sel_r, level);
            Green <= scale(sel_g, level);
            Blue  <= scale(sel_b, level);
        end
    end

endmodule

// File: tb/tb_screen_compositor.sv
// Self-checking bench for screen_compositor. It runs the 4-screen instance plus a
// 3-screen instance that exercises the invalid-index fallback. It adapts to
// SCREEN_FADE_EN.
module tb_screen_compositor;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct {
        logic [3:0]  r, g, b;
        logic [10:0] fa;
        logic [1:0]  sel;
        logic [3:0]  er, eg, eb;
        logic [10:0] efa;
        logic [1:0]  eact;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  screen_sel = 2'd0;
    logic [15:0] src_red = '0, src_green = '0, src_blue = '0;
    logic [43:0] src_font_addr = '0;
    logic [10:0] font_address;
    logic [3:0]  Red, Green, Blue;
    logic [1:0]  active_screen;
    logic        busy;

    logic [1:0]  sel3 = 2'd0;
    logic [11:0] s3_red = 12'h321, s3_green = 12'h654, s3_blue = 12'h987;
    logic [32:0] s3_fa = {11'h0AA, 11'h055, 11'h011};
    logic [10:0] fa3;
    logic [3:0]  r3, g3, b3;
    logic [1:0]  act3;
    logic        busy3;

    logic [3:0]  m_r[4], m_g[4], m_b[4];
    logic [10:0] m_fa[4];
    rgb_t        sb[$];
    vec_t        vecs[5];
    int          total = 0;
    int          passed = 0;

    screen_compositor dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .screen_sel(screen_sel),
        .src_red(src_red), .src_green(src_green), .src_blue(src_blue),
        .src_font_addr(src_font_addr), .font_address(font_address),
        .Red(Red), .Green(Green), .Blue(Blue),
        .active_screen(active_screen), .busy(busy)
    );

    screen_compositor #(.NUM_SCREENS(3)) dut3 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .screen_sel(sel3),
        .src_red(s3_red), .src_green(s3_green), .src_blue(s3_blue),
        .src_font_addr(s3_fa), .font_address(fa3),
        .Red(r3), .Green(g3), .Blue(b3),
        .active_screen(act3), .busy(busy3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic sb_pop(input string nm);
        rgb_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, expected an entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_red"},   32'(Red),   32'(e.r));
            chk({nm, "_green"}, 32'(Green), 32'(e.g));
            chk({nm, "_blue"},  32'(Blue),  32'(e.b));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b, input logic [10:0] fa);
        src_red[idx*4 +: 4]        = r;
        src_green[idx*4 +: 4]      = g;
        src_blue[idx*4 +: 4]       = b;
        src_font_addr[idx*11 +: 11] = fa;
        m_r[idx] = r; m_g[idx] = g; m_b[idx] = b; m_fa[idx] = fa;
    endtask

`ifdef SCREEN_FADE_EN
    function automatic logic [3:0] fscale(input logic [3:0] c, input int lvl);
        return 4'((int'(c) * lvl) >> 4);
    endfunction

    task automatic push_scaled(input int idx, input int lvl);
        sb.push_back('{r: fscale(m_r[idx], lvl), g: fscale(m_g[idx], lvl),
                       b: fscale(m_b[idx], lvl)});
    endtask

    // One frame_start pulse, then one more edge so the colour register picks up the new level.
    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rgb_t prev;
        vecs[0] = '{r:4'hF, g:4'hA, b:4'h4, fa:11'h123, sel:2'd0, er:4'hF, eg:4'hA, eb:4'h4, efa:11'h123, eact:2'd0};
        vecs[1] = '{r:4'h0, g:4'h0, b:4'h0, fa:11'h000, sel:2'd0, er:4'h0, eg:4'h0, eb:4'h0, efa:11'h000, eact:2'd0};
        vecs[2] = '{r:4'h1, g:4'h2, b:4'h3, fa:11'h7FF, sel:2'd0, er:4'h1, eg:4'h2, eb:4'h3, efa:11'h7FF, eact:2'd0};
        vecs[3] = '{r:4'h8, g:4'h7, b:4'hC, fa:11'h555, sel:2'd0, er:4'h8, eg:4'h7, eb:4'hC, efa:11'h555, eact:2'd0};
        // A selection change with no frame_start must not be acted on.
        vecs[4] = '{r:4'hF, g:4'hA, b:4'h4, fa:11'h2C4, sel:2'd2, er:4'hF, eg:4'hA, eb:4'h4, efa:11'h2C4, eact:2'd0};

        set_src(0, 4'h0, 4'h0, 4'h0, 11'h000);
        set_src(1, 4'h1, 4'h1, 4'h1, 11'h111);
        set_src(2, 4'h2, 4'h2, 4'h2, 11'h222);
        set_src(3, 4'h3, 4'h3, 4'h3, 11'h333);

        #1 reset = 1'b1;
        #1;
        chk("rst_red", 32'(Red), 0);
        chk("rst_active", 32'(active_screen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst3_red", 32'(r3), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_blue_after", 32'(Blue), 0);

        prev = '0;
        for (int i = 0; i < 5; i++) begin
            set_src(0, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].fa);
            screen_sel = vecs[i].sel;
            #1;
            chk($sformatf("v%0d_font", i), 32'(font_address), 32'(vecs[i].efa));
            chk($sformatf("v%0d_latency", i), 32'({Red, Green, Blue}), 32'(prev));
            sb.push_back('{r: vecs[i].er, g: vecs[i].eg, b: vecs[i].eb});
            prev = '{r: vecs[i].er, g: vecs[i].eg, b: vecs[i].eb};
            tick();
            sb_pop($sformatf("v%0d", i));
            chk($sformatf("v%0d_active", i), 32'(active_screen), 32'(vecs[i].eact));
        end

`ifdef SCREEN_FADE_EN
        // Full 0 -> 2 transition.
        set_src(2, 4'hF, 4'h5, 4'h8, 11'h222);
        screen_sel = 2'd2;
        for (int k = 1; k <= 35; k++) begin
            int lvl, act;
            lvl = (k == 1) ? 16 : (k <= 17) ? 17 - k : (k == 18) ? 0 : (k <= 34) ? k - 18 : 16;
            act = (k < 18) ? 0 : 2;
            pulse();
            chk($sformatf("fade_k%0d_active", k), 32'(active_screen), 32'(act));
            chk($sformatf("fade_k%0d_busy", k), 32'(busy), (k < 35) ? 1 : 0);
            push_scaled(act, lvl);
            sb_pop($sformatf("fade_k%0d", k));
        end

        // Abort: 2 -> 1 requested, return to 2 once the level reaches 10.
        set_src(1, 4'hE, 4'hE, 4'hE, 11'h111);
        screen_sel = 2'd1;
        for (int k = 1; k <= 15; k++) begin
            int lvl;
            lvl = (k == 1) ? 16 : (k <= 7) ? 17 - k : (k == 8) ? 10 : (k <= 14) ? k + 2 : 16;
            pulse();
            if (k == 7) screen_sel = 2'd2;
            chk($sformatf("abort_k%0d_active", k), 32'(active_screen), 2);
            push_scaled(2, lvl);
            sb_pop($sformatf("abort_k%0d", k));
        end
        chk("abort_busy_end", 32'(busy), 0);

        // Fade towards 0 until the level is 5, then reset below.
        screen_sel = 2'd0;
        for (int k = 1; k <= 12; k++) pulse();
        chk("mid_red_lvl5", 32'(Red), 32'(fscale(m_r[2], 5)));
        chk("mid_busy", 32'(busy), 1);
`else
        // Immediate switch 0 -> 3.
        set_src(3, 4'h5, 4'h6, 4'h7, 11'h3AB);
        screen_sel = 2'd3;
        tick();
        tick();
        chk("nofade_hold_active", 32'(active_screen), 0);
        frame_start = 1'b1;
        sb.push_back('{r: m_r[0], g: m_g[0], b: m_b[0]});
        tick();
        frame_start = 1'b0;
        chk("nofade_swap_active", 32'(active_screen), 3);
        chk("nofade_swap_font", 32'(font_address), 32'h3AB);
        sb_pop("nofade_pre");
        sb.push_back('{r: 4'h5, g: 4'h6, b: 4'h7});
        tick();
        sb_pop("nofade_post");
        chk("nofade_busy", 32'(busy), 0);
        set_src(3, 4'h9, 4'h0, 4'hE, 11'h3AB);
        sb.push_back('{r: 4'h9, g: 4'h0, b: 4'hE});
        tick();
        sb_pop("nofade_follow");
`endif

        // Asynchronous reset in the middle of activity.
        reset = 1'b1;
        #1;
        chk("async_red", 32'(Red), 0);
        chk("async_green", 32'(Green), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_active", 32'(active_screen), 0);
        reset = 1'b0;
        screen_sel = 2'd0;
        sb.push_back('{r: m_r[0], g: m_g[0], b: m_b[0]});
        tick();
        sb_pop("post_reset");

        // Invalid index on the 3-screen instance.
        sel3 = 2'd3;
`ifdef SCREEN_FADE_EN
        for (int k = 0; k < 35; k++) pulse();
`else
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
`endif
        chk("inv_active", 32'(act3), 3);
        chk("inv_font", 32'(fa3), 0);
        chk("inv_red", 32'(r3), 3);
        chk("inv_green", 32'(g3), 6);
        chk("inv_blue", 32'(b3), 2);
        chk("inv_busy", 32'(busy3), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
